bsg_manycore_link_fifo_arbiter: RTL
===================================

Name: bsg_manycore_link_fifo_arbiter

Overview:
- Shares the host-side fifo->manycore request channel of the manycore link/FIFO bridge among num_req_p requesters (e.g. host MMIO, loader, DMA).
- Round-robin arbitrates requests and gates issue on a local out-credit counter.
- Tags each request's load_id with the requester index, then steers returned packets back to their requester by that tag.
- Provides a fence: stops granting until every outstanding request has returned.

Parameters:
num_req_p, 2, number of requesters (power of 2, >=2)
fifo_width_p, 128, width of every FIFO word
max_out_credits_p, 16, outstanding-request limit; matches the endpoint's credit count
load_id_offset_p, 0, bit position of the load_id field in a request word
ret_load_id_offset_p, 0, bit position of the load_id field in a returned word
lg_req_lp, $clog2(num_req_p), requester tag width (localparam)
credit_width_lp, $clog2(max_out_credits_p+1), credit counter width (localparam)

Ports:
clk_i  in  1  clock
reset_i  in  1  asynchronous active-high reset
req_v_i  in  num_req_p  per-requester request valid
req_data_i  in  num_req_p*fifo_width_p  per-requester request words, requester i at [i*fifo_width_p +: fifo_width_p]
req_yumi_o  out  num_req_p  request dequeued (one-hot or zero)
link_data_o  out  fifo_width_p  request word to the bridge's link_data_i
link_v_o  out  1  request valid
link_ready_i  in  1  bridge ready
link_returned_i  in  fifo_width_p  returned word from the bridge
link_returned_v_i  in  1  returned word valid
link_returned_yumi_o  out  1  returned word dequeued
resp_data_o  out  fifo_width_p  returned word, broadcast to all requesters
resp_v_o  out  num_req_p  one-hot valid for the tagged requester
resp_yumi_i  in  num_req_p  requester consumes response
fence_i  in  1  level; request a fence
fence_done_o  out  1  fence complete
credits_o  out  credit_width_lp  current local credits

Behaviour:
- Reset values: state=eIdle, credits_r=max_out_credits_p, rr pointer=0, link_v_o=0, req_yumi_o=0, fence_done_o=0, resp_v_o=0.
- Request path is registered (one output slot):
  - In eIdle, if credits_r>0 and any req_v_i is set and no fence is pending, grant the lowest index >= rr pointer (wrapping).
  - Capture that word into the slot with load_id[lg_req_lp-1:0] replaced by the grant index; assert req_yumi_o[grant] that same cycle.
  - Decrement credits_r; go to eSend.
  - link_v_o is asserted from the next cycle. Latency from req_v_i to link_v_o is 1 cycle.
- eSend: hold link_v_o and link_data_o stable until link_ready_i. On the handshake, rr pointer = grant+1 mod num_req_p.
  - If another grant is possible in that cycle, reload the slot and stay in eSend (back-to-back, 1 word/cycle). Otherwise go to eIdle.
- Credit accounting:
  - Decrement at grant; increment on link_returned_yumi_o. Both in one cycle leaves credits_r unchanged.
  - At credits_r==0 no grant is made.
  - An increment at credits_r==max_out_credits_p is a protocol error: saturate and $error.
  - credits_o=credits_r.
- Fence:
  - While fence_i is high, no new grants are made; an in-flight slot still completes.
  - Go to eFence once the slot is empty.
  - In eFence, fence_done_o=1 when credits_r==max_out_credits_p.
  - When fence_i deasserts, return to eIdle; fence_done_o drops the same cycle.
- Return path is combinational:
  - tag = link_returned_i[ret_load_id_offset_p +: lg_req_lp].
  - resp_v_o = link_returned_v_i << tag; resp_data_o = link_returned_i.
  - link_returned_yumi_o = resp_yumi_i[tag] & link_returned_v_i.
  - A yumi from a non-tagged requester is ignored and flagged by an assertion.
- Reset mid-operation: the slot is discarded; credits return to max. The environment must reset the bridge together with this block.
- The request word outside the tag bits passes through unmodified.

Decomposition:
- Package bsg_manycore_link_fifo_arbiter_pkg: state enum (eIdle, eSend, eFence) and a tag-insert helper function.
- Sub-module: bsg_manycore_link_rr_arbiter, a round-robin grant generator (inputs: reqs, pointer, enable; output: one-hot grant plus index).
- The credit counter and the slot stay in the top module.

Test Plan:
1. Single requester, num_req_p=2: req 0 writes word 0xA5 with load_id=0x7F0 -> link_v_o next cycle with load_id=0x7F0; credits_o 16->15; returned word with tag 0 -> resp_v_o=2'b01, credits back to 16.
2. Both requesters valid continuously, link_ready_i=1 -> grants alternate 0,1,0,1 at one word per cycle; returned tags steer responses to the matching requester.
3. 16 requests with no returns -> the 17th request gets no req_yumi_o and credits_o=0. Return one word -> grant on the next cycle.
4. Back-pressure: link_ready_i=0 for 5 cycles -> link_data_o stable and no further req_yumi_o; on ready, the handshake completes and the pointer advances.
5. Fence with 3 outstanding: fence_i=1 -> no grants; fence_done_o rises in the cycle credits reach 16 after the 3rd return and falls when fence_i=0.
6. Simultaneous grant and return at credits 15 -> credits stay 15. Reset asserted with the slot full -> link_v_o=0 immediately and credits_o=16.

Source files
------------

// File: rtl/bsg_manycore_link_fifo_arbiter_pkg.sv
// Shared types and helpers for the manycore link FIFO request arbiter.
// The FIFO word width is a module parameter, so the tag helper works on a wide container word.
package bsg_manycore_link_fifo_arbiter_pkg;

    typedef enum logic [1:0] {
        eIdle  = 2'd0,
        eSend  = 2'd1,
        eFence = 2'd2
    } state_e;

    localparam int unsigned max_fifo_width_gp = 1024;

    // Replace the masked field of a word with the matching bits of a pre-shifted tag.
    function automatic logic [max_fifo_width_gp-1:0] tag_insert(
        input logic [max_fifo_width_gp-1:0] word_i,
        input logic [max_fifo_width_gp-1:0] mask_i,
        input logic [max_fifo_width_gp-1:0] tag_i
    );
        return (word_i & ~mask_i) | (tag_i & mask_i);
    endfunction

endpackage

// File: rtl/bsg_manycore_link_fifo_arbiter_chk.sv
// Protocol checks for the link FIFO arbiter: stray response consumes and credit overflow.
module bsg_manycore_link_fifo_arbiter_chk #(
    parameter int num_req_p = 2
) (
    input logic                 clk_i,
    input logic                 reset_i,
    input logic                 ret_v_i,
    input logic [num_req_p-1:0] resp_v_i,
    input logic [num_req_p-1:0] resp_yumi_i,
    input logic                 credit_inc_i,
    input logic                 credit_dec_i,
    input logic                 credits_full_i
);

    // Sample protocol rules once per cycle outside reset.
    always @(posedge clk_i) begin
        if (!reset_i) begin
            assert (!(ret_v_i && |(resp_yumi_i & ~resp_v_i)))
                else $error("link arbiter: response consumed by a non-tagged requester");
            assert (!(credit_inc_i && !credit_dec_i && credits_full_i))
                else $error("link arbiter: credit return with all credits already home");
        end
    end

endmodule

// File: rtl/bsg_manycore_link_rr_arbiter.sv
// Round-robin grant generator: picks the lowest requesting index at or above the pointer, wrapping.
module bsg_manycore_link_rr_arbiter #(
    parameter int num_req_p = 2,
    localparam int lg_req_lp = $clog2(num_req_p)
) (
    input  logic [num_req_p-1:0] reqs_i,
    input  logic [lg_req_lp-1:0] ptr_i,
    input  logic                 en_i,
    output logic [num_req_p-1:0] grant_o,
    output logic [lg_req_lp-1:0] idx_o,
    output logic                 v_o
);

    logic [lg_req_lp-1:0] cand_s;
    logic                 found_s;

    // Scan from the pointer upward; power-of-two count makes the wrap a natural overflow.
    always_comb begin
        cand_s  = ptr_i;
        found_s = 1'b0;
        idx_o   = ptr_i;
        for (int i = 0; i < num_req_p; i++) begin
            cand_s = ptr_i + lg_req_lp'(i);
            if (!found_s && reqs_i[cand_s]) begin
                found_s = 1'b1;
                idx_o   = cand_s;
            end else begin
                found_s = found_s;
            end
        end
        v_o = en_i & found_s;
        if (v_o) begin
            grant_o = {{(num_req_p-1){1'b0}}, 1'b1} << idx_o;
        end else begin
            grant_o = {num_req_p{1'b0}};
        end
    end

endmodule

// File: rtl/bsg_manycore_link_fifo_arbiter.sv
// Shares the host->manycore request channel among requesters with round-robin, credits and fence,
// and steers returned words back to the requester named in their load_id tag.
module bsg_manycore_link_fifo_arbiter
    import bsg_manycore_link_fifo_arbiter_pkg::*;
#(
    parameter int num_req_p            = 2,
    parameter int fifo_width_p         = 128,
    parameter int max_out_credits_p    = 16,
    parameter int load_id_offset_p     = 0,
    parameter int ret_load_id_offset_p = 0,
    localparam int lg_req_lp           = $clog2(num_req_p),
    localparam int credit_width_lp     = $clog2(max_out_credits_p+1)
) (
    input  logic                              clk_i,
    input  logic                              reset_i,
    input  logic [num_req_p-1:0]              req_v_i,
    input  logic [num_req_p*fifo_width_p-1:0] req_data_i,
    output logic [num_req_p-1:0]              req_yumi_o,
    output logic [fifo_width_p-1:0]           link_data_o,
    output logic                              link_v_o,
    input  logic                              link_ready_i,
    input  logic [fifo_width_p-1:0]           link_returned_i,
    input  logic                              link_returned_v_i,
    output logic                              link_returned_yumi_o,
    output logic [fifo_width_p-1:0]           resp_data_o,
    output logic [num_req_p-1:0]              resp_v_o,
    input  logic [num_req_p-1:0]              resp_yumi_i,
    input  logic                              fence_i,
    output logic                              fence_done_o,
    output logic [credit_width_lp-1:0]        credits_o
);

    localparam logic [credit_width_lp-1:0] max_credits_lp = credit_width_lp'(max_out_credits_p);
    localparam logic [fifo_width_p-1:0] tag_mask_lp =
        {{(fifo_width_p-lg_req_lp){1'b0}}, {lg_req_lp{1'b1}}} << load_id_offset_p;

    state_e                     state_q, state_d;
    logic [credit_width_lp-1:0] credits_q, credits_d;
    logic [lg_req_lp-1:0]       rr_ptr_q, rr_ptr_d;
    logic [lg_req_lp-1:0]       slot_grant_q, slot_grant_d;
    logic [fifo_width_p-1:0]    slot_q, slot_d;

    logic [fifo_width_p-1:0]    req_words_s [num_req_p];
    logic [fifo_width_p-1:0]    tag_shift_s;
    logic [fifo_width_p-1:0]    tagged_word_s;
    logic [lg_req_lp-1:0]       arb_ptr_s;
    logic [lg_req_lp-1:0]       arb_idx_s;
    logic [num_req_p-1:0]       arb_grant_s;
    logic                       arb_en_s;
    logic                       grant_s;
    logic                       handshake_s;
    logic [lg_req_lp-1:0]       ret_tag_s;
    logic                       ret_yumi_s;

    // Unpack the flat request bus and build the tagged word of the current winner.
    always_comb begin
        for (int i = 0; i < num_req_p; i++) begin
            req_words_s[i] = req_data_i[i*fifo_width_p +: fifo_width_p];
        end
        tag_shift_s   = {{(fifo_width_p-lg_req_lp){1'b0}}, arb_idx_s} << load_id_offset_p;
        tagged_word_s = fifo_width_p'(tag_insert(max_fifo_width_gp'(req_words_s[arb_idx_s]),
                                                 max_fifo_width_gp'(tag_mask_lp),
                                                 max_fifo_width_gp'(tag_shift_s)));
    end

    // A new grant needs a free slot (idle, or draining this cycle), a credit and no fence request.
    always_comb begin
        handshake_s = (state_q == eSend) & link_ready_i;
        arb_en_s    = ((state_q == eIdle) | handshake_s) & (credits_q != '0) & ~fence_i;
        if (state_q == eSend) begin
            arb_ptr_s = slot_grant_q + lg_req_lp'(1'b1);
        end else begin
            arb_ptr_s = rr_ptr_q;
        end
    end

    bsg_manycore_link_rr_arbiter #(
        .num_req_p (num_req_p)
    ) rr_arb (
        .reqs_i  (req_v_i),
        .ptr_i   (arb_ptr_s),
        .en_i    (arb_en_s),
        .grant_o (arb_grant_s),
        .idx_o   (arb_idx_s),
        .v_o     (grant_s)
    );

    // Return steering is purely combinational on the tag carried in the returned word.
    always_comb begin
        ret_tag_s            = link_returned_i[ret_load_id_offset_p +: lg_req_lp];
        resp_v_o             = {{(num_req_p-1){1'b0}}, link_returned_v_i} << ret_tag_s;
        resp_data_o          = link_returned_i;
        ret_yumi_s           = resp_yumi_i[ret_tag_s] & link_returned_v_i;
        link_returned_yumi_o = ret_yumi_s;
    end

    // Credit counter: grant spends, return refunds, simultaneous events cancel, overflow saturates.
    always_comb begin
        credits_d = credits_q;
        if (grant_s && !ret_yumi_s) begin
            credits_d = credits_q - credit_width_lp'(1'b1);
        end else if (ret_yumi_s && !grant_s && (credits_q != max_credits_lp)) begin
            credits_d = credits_q + credit_width_lp'(1'b1);
        end else begin
            credits_d = credits_q;
        end
    end

    // Slot and state sequencing.
    always_comb begin
        state_d      = state_q;
        slot_d       = slot_q;
        slot_grant_d = slot_grant_q;
        rr_ptr_d     = rr_ptr_q;
        case (state_q)
            eIdle: begin
                if (grant_s) begin
                    slot_d       = tagged_word_s;
                    slot_grant_d = arb_idx_s;
                    state_d      = eSend;
                end else if (fence_i) begin
                    state_d = eFence;
                end else begin
                    state_d = eIdle;
                end
            end
            eSend: begin
                if (link_ready_i) begin
                    rr_ptr_d = slot_grant_q + lg_req_lp'(1'b1);
                    if (grant_s) begin
                        slot_d       = tagged_word_s;
                        slot_grant_d = arb_idx_s;
                        state_d      = eSend;
                    end else if (fence_i) begin
                        state_d = eFence;
                    end else begin
                        state_d = eIdle;
                    end
                end else begin
                    state_d = eSend;
                end
            end
            eFence: begin
                if (!fence_i) begin
                    state_d = eIdle;
                end else begin
                    state_d = eFence;
                end
            end
            default: begin
                state_d = eIdle;
            end
        endcase
    end

    // State registers; reset drops the slot and refills credits.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q      <= eIdle;
            credits_q    <= max_credits_lp;
            rr_ptr_q     <= '0;
            slot_grant_q <= '0;
            slot_q       <= '0;
        end else begin
            state_q      <= state_d;
            credits_q    <= credits_d;
            rr_ptr_q     <= rr_ptr_d;
            slot_grant_q <= slot_grant_d;
            slot_q       <= slot_d;
        end
    end

    assign req_yumi_o   = arb_grant_s;
    assign link_v_o     = (state_q == eSend);
    assign link_data_o  = slot_q;
    assign credits_o    = credits_q;
    assign fence_done_o = (state_q == eFence) & fence_i & (credits_q == max_credits_lp);

    bsg_manycore_link_fifo_arbiter_chk #(
        .num_req_p (num_req_p)
    ) chk (
        .clk_i          (clk_i),
        .reset_i        (reset_i),
        .ret_v_i        (link_returned_v_i),
        .resp_v_i       (resp_v_o),
        .resp_yumi_i    (resp_yumi_i),
        .credit_inc_i   (ret_yumi_s),
        .credit_dec_i   (grant_s),
        .credits_full_i (credits_q == max_credits_lp)
    );

endmodule
